// File: rtl/bus_interfaces_pkg.sv
// bus_interfaces_pkg: struct types for the external upstream bus and the AXI-Stream downstream bus
package bus_interfaces_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } external_m2s_t;

    typedef struct packed {
        logic ready;
    } external_s2m_t;

    typedef struct packed {
        logic        tvalid;
        logic [63:0] tdata;
        logic [7:0]  tkeep;
        logic [63:0] tuser;
        logic        tlast;
    } axis_m2s_t;

    typedef struct packed {
        logic tready;
    } axis_s2m_t;

endpackage

// File: rtl/ext2axis_ingress.sv
// ext2axis_ingress: buffers external-bus beats in a FIFO and forwards them as AXI-Stream with per-beat tuser metadata
// Ports:
//   clk, rst_n   - single clock, synchronous active-low reset
//   ext_m2s_i    - upstream valid/data/keep/last
//   ext_s2m_o    - upstream ready (occupancy based only)
//   axis_m2s_o   - downstream tvalid/tdata/tkeep/tuser/tlast from the FIFO head
//   axis_s2m_i   - downstream tready
//   pkt_cnt_o    - packets delivered downstream (wrapping)
//   proto_err_o  - sticky keep-violation flag
module ext2axis_ingress
    import bus_interfaces_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int PKT_CNT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  external_m2s_t            ext_m2s_i,
    output external_s2m_t            ext_s2m_o,
    output axis_m2s_t                axis_m2s_o,
    input  axis_s2m_t                axis_s2m_i,
    output logic [PKT_CNT_WIDTH-1:0] pkt_cnt_o,
    output logic                     proto_err_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [63:0]   mem_data [FIFO_DEPTH];
    logic [63:0]   mem_user [FIFO_DEPTH];
    logic [7:0]    mem_keep [FIFO_DEPTH];
    logic          mem_last [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [15:0]   pkt_seq, beat_idx;
    logic [3:0]    keep_cnt;
    logic          keep_err, ready, valid, push, pop;
    logic [63:0]   tuser_in;

    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < 8; i++) keep_cnt = keep_cnt + 4'(ext_m2s_i.keep[i]);
    end

    assign keep_err = (!ext_m2s_i.last && ext_m2s_i.keep != 8'hFF) || ext_m2s_i.keep == 8'h00;
    assign tuser_in = {27'b0, keep_err, keep_cnt, beat_idx, pkt_seq};

    // depth is a power of two, so the occupancy MSB alone means full
    assign ready = rst_n && !count[AW];
    assign valid = rst_n && count != '0;
    assign push  = ext_m2s_i.valid && ready;
    assign pop   = valid && axis_s2m_i.tready;

    assign ext_s2m_o.ready = ready;

    always_comb begin
        axis_m2s_o        = '0;
        axis_m2s_o.tvalid = valid;
        if (valid) begin
            axis_m2s_o.tdata = mem_data[rd_ptr];
            axis_m2s_o.tkeep = mem_keep[rd_ptr];
            axis_m2s_o.tuser = mem_user[rd_ptr];
            axis_m2s_o.tlast = mem_last[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= ext_m2s_i.data;
            mem_keep[wr_ptr] <= ext_m2s_i.keep;
            mem_last[wr_ptr] <= ext_m2s_i.last;
            mem_user[wr_ptr] <= tuser_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            pkt_seq     <= '0;
            beat_idx    <= '0;
            pkt_cnt_o   <= '0;
            proto_err_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + AW'(1);
                pkt_seq  <= ext_m2s_i.last ? pkt_seq + 16'd1 : pkt_seq;
                beat_idx <= ext_m2s_i.last ? 16'd0 : beat_idx + 16'(beat_idx != 16'hFFFF);
                if (keep_err) proto_err_o <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                if (mem_last[rd_ptr]) pkt_cnt_o <= pkt_cnt_o + PKT_CNT_WIDTH'(1);
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_ext2axis_ingress.sv
// tb_ext2axis_ingress: scoreboard bench for ext2axis_ingress
module tb_ext2axis_ingress;
    import bus_interfaces_pkg::*;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [63:0] tuser;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    external_m2s_t ext_m2s = '0;
    external_s2m_t ext_s2m;
    axis_m2s_t     axis_m2s;
    axis_s2m_t     axis_s2m = '0;
    logic [31:0]   pkt_cnt;
    logic          proto_err;

    beat_t       q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          acc_cnt = 0;
    int          out_cnt = 0;
    logic [15:0] seq_m = '0;
    logic [15:0] bidx_m = '0;
    logic [31:0] pcnt_m = '0;
    logic        perr_m = 1'b0;
    logic        rnd_en = 1'b0;

    ext2axis_ingress #(.FIFO_DEPTH(4), .PKT_CNT_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ext_m2s_i  (ext_m2s),
        .ext_s2m_o  (ext_s2m),
        .axis_m2s_o (axis_m2s),
        .axis_s2m_i (axis_s2m),
        .pkt_cnt_o  (pkt_cnt),
        .proto_err_o(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: expected beats enter at input handshakes, are compared at output handshakes
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            seq_m  = '0;
            bidx_m = '0;
            pcnt_m = '0;
            perr_m = 1'b0;
        end else begin
            if (axis_m2s.tvalid && axis_s2m.tready) begin
                out_cnt++;
                if (q.size() == 0) check("underflow", 64'd1, 64'd0);
                else begin
                    beat_t e;
                    e = q.pop_front();
                    check("tdata", axis_m2s.tdata, e.data);
                    check("tkeep_tlast", {55'd0, axis_m2s.tkeep, axis_m2s.tlast}, {55'd0, e.keep, e.last});
                    check("tuser", axis_m2s.tuser, e.tuser);
                    if (e.last) pcnt_m++;
                end
            end
            if (ext_m2s.valid && ext_s2m.ready) begin
                beat_t b;
                logic  kerr;
                logic [3:0] pc;
                kerr = (!ext_m2s.last && ext_m2s.keep != 8'hFF) || ext_m2s.keep == 8'h00;
                pc = 4'($countones(ext_m2s.keep));
                b.data  = ext_m2s.data;
                b.keep  = ext_m2s.keep;
                b.last  = ext_m2s.last;
                b.tuser = {27'd0, kerr, pc, bidx_m, seq_m};
                q.push_back(b);
                acc_cnt++;
                if (kerr) perr_m = 1'b1;
                if (ext_m2s.last) begin
                    seq_m++;
                    bidx_m = '0;
                end else if (bidx_m != 16'hFFFF) bidx_m++;
            end
        end
    end

    always @(posedge clk) if (rnd_en) #1 axis_s2m.tready = ($urandom_range(0, 3) != 0);

    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
        bit got = 0;
        ext_m2s.valid = 1'b1;
        ext_m2s.data  = d;
        ext_m2s.keep  = k;
        ext_m2s.last  = l;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            got = ext_s2m.ready;
        end
        if (!got) check("send_timeout", 64'd0, 64'd1);
        else begin
            @(posedge clk);
            #1;
        end
        ext_m2s.valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        axis_s2m.tready = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = (q.size() == 0) && !axis_m2s.tvalid;
        end
        check("drain_empty", 64'(done), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ready", 64'(ext_s2m.ready), 64'd0);
            check("rst_tvalid", 64'(axis_m2s.tvalid), 64'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(ext_s2m.ready), 64'd1);
        check("post_rst_tvalid", 64'(axis_m2s.tvalid), 64'd0);
        check("post_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("post_rst_proto_err", 64'(proto_err), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a0, o0;
        do_reset();

        // single 3-beat packet, minimum latency
        axis_s2m.tready = 1'b1;
        send(64'h1111_0000_0000_0001, 8'hFF, 1'b0);
        check("latency_tvalid", 64'(axis_m2s.tvalid), 64'd1);
        send(64'h1111_0000_0000_0002, 8'hFF, 1'b0);
        send(64'h1111_0000_0000_0003, 8'h0F, 1'b1);
        drain();
        check("pkt_cnt_one", 64'(pkt_cnt), 64'd1);
        check("proto_err_clean", 64'(proto_err), 64'd0);

        // backpressure: 6 offered, 4 accepted
        axis_s2m.tready = 1'b0;
        a0 = acc_cnt;
        o0 = out_cnt;
        for (int i = 0; i < 6; i++) begin
            ext_m2s.valid = 1'b1;
            ext_m2s.data  = 64'h2222_0000_0000_0000 + 64'(i);
            ext_m2s.keep  = 8'hFF;
            ext_m2s.last  = (i == 3);
            @(posedge clk);
            #1;
        end
        check("bp_accepted", 64'(acc_cnt - a0), 64'd4);
        @(negedge clk);
        check("bp_ready_low", 64'(ext_s2m.ready), 64'd0);
        check("bp_no_output", 64'(out_cnt - o0), 64'd0);
        ext_m2s.valid = 1'b0;
        drain();
        check("bp_drained", 64'(out_cnt - o0), 64'd4);
        check("pkt_cnt_two", 64'(pkt_cnt), 64'd2);

        // keep violation mid-packet; flag is sticky
        send(64'h3333_0000_0000_0001, 8'hFF, 1'b0);
        send(64'h3333_0000_0000_0002, 8'h3F, 1'b0);
        send(64'h3333_0000_0000_0003, 8'hF0, 1'b1);
        drain();
        check("proto_err_set", 64'(proto_err), 64'd1);
        send(64'h3333_0000_0000_0004, 8'hFF, 1'b1);
        drain();
        check("proto_err_sticky", 64'(proto_err), 64'd1);
        check("pkt_cnt_model", 64'(pkt_cnt), 64'(pcnt_m));

        // reset with 3 beats of a 5-beat packet buffered
        axis_s2m.tready = 1'b0;
        for (int i = 0; i < 3; i++) send(64'h4444_0000_0000_0000 + 64'(i), 8'hFF, 1'b0);
        @(negedge clk);
        check("pre_rst_tvalid", 64'(axis_m2s.tvalid), 64'd1);
        do_reset();
        axis_s2m.tready = 1'b1;
        send(64'h4444_0000_0000_00AA, 8'h01, 1'b1);
        drain();
        check("post_rst_pkt", 64'(pkt_cnt), 64'd1);

        // pkt_seq wrap: seq 0..FFFE, then FFFF, then 0
        do_reset();
        axis_s2m.tready = 1'b1;
        for (int i = 0; i < 65535; i++) send(64'(i), 8'hFF, 1'b1);
        check("seq_before_wrap", 64'(seq_m), 64'hFFFF);
        send(64'h5555_0000_0000_FFFF, 8'hFF, 1'b1);
        send(64'h5555_0000_0001_0000, 8'hFF, 1'b1);
        drain();
        check("wrap_pkt_cnt", 64'(pkt_cnt), 64'd65537);

        // random valid/tready over 10k beats
        do_reset();
        a0 = acc_cnt;
        o0 = out_cnt;
        rnd_en = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            logic       l;
            logic [7:0] k;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            l = ($urandom_range(0, 4) == 0);
            k = (l || $urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255)) : 8'hFF;
            send({$urandom, $urandom}, k, l);
        end
        rnd_en = 1'b0;
        @(posedge clk);
        #2;
        drain();
        check("rnd_no_loss", 64'(out_cnt - o0), 64'(acc_cnt - a0));
        check("rnd_count", 64'(acc_cnt - a0), 64'd10000);
        check("rnd_pkt_cnt", 64'(pkt_cnt), 64'(pcnt_m));
        check("rnd_proto_err", 64'(proto_err), 64'(perr_m));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
